// File: rtl/countdown_timer_multi.sv
// Loadable down-counter with clock prescaler, one-shot/auto-reload modes, pause, abort and restart.
// Optional registered Warn output is enabled by defining COUNTDOWN_WARN_EN.
module countdown_timer_multi #(
    parameter int WIDTH      = 10,
    parameter int TICK_DIV   = 4
`ifdef COUNTDOWN_WARN_EN
   ,parameter int WARN_LEVEL = 3
`endif
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_pause,
    input  logic             i_abort,
    input  logic             i_autoReload,
    input  logic [WIDTH-1:0] i_loadValue,
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_warn
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [PW-1:0]    r_prescaler;
    logic [WIDTH-1:0] r_reload;
    logic             r_mode;
    logic             r_busy;
    logic             r_done;

    state_t           w_stateNext;
    logic [WIDTH-1:0] w_countNext;
    logic [PW-1:0]    w_prescalerNext;
    logic [WIDTH-1:0] w_reloadNext;
    logic             w_modeNext;
    logic             w_doneNext;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_prescaler <= '0;
            r_reload    <= '0;
            r_mode      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_count     <= w_countNext;
            r_prescaler <= w_prescalerNext;
            r_reload    <= w_reloadNext;
            r_mode      <= w_modeNext;
            r_busy      <= (w_stateNext != IDLE);
            r_done      <= w_doneNext;
        end
    end

    // Priority Abort > Start > Pause > tick; the edge that releases Pause already counts.
    always_comb begin
        w_stateNext     = r_state;
        w_countNext     = r_count;
        w_prescalerNext = r_prescaler;
        w_reloadNext    = r_reload;
        w_modeNext      = r_mode;
        w_doneNext      = 1'b0;
        if (i_abort) begin
            w_countNext     = '0;
            w_prescalerNext = '0;
            w_stateNext     = IDLE;
        end else if (i_start) begin
            w_countNext     = i_loadValue;
            w_reloadNext    = i_loadValue;
            w_modeNext      = i_autoReload;
            w_prescalerNext = '0;
            if (i_loadValue == '0) begin
                w_stateNext = IDLE;
                w_doneNext  = 1'b1;
            end else begin
                w_stateNext = i_pause ? PAUSED : RUN;
            end
        end else begin
            case (r_state)
                RUN, PAUSED: begin
                    if (i_pause) begin
                        w_stateNext = PAUSED;
                    end else begin
                        w_stateNext = RUN;
                        if (r_prescaler == PRE_LAST) begin
                            w_prescalerNext = '0;
                            // Count never sits at 0 while running, so the decrement cannot wrap.
                            if (r_count == WIDTH'(1)) begin
                                w_doneNext = 1'b1;
                                if (r_mode) begin
                                    w_countNext = r_reload;
                                end else begin
                                    w_countNext = '0;
                                    w_stateNext = IDLE;
                                end
                            end else begin
                                w_countNext = r_count - WIDTH'(1);
                            end
                        end else begin
                            w_prescalerNext = r_prescaler + PW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef COUNTDOWN_WARN_EN
    logic r_warn;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_warn <= 1'b0;
        end else begin
            r_warn <= (w_stateNext != IDLE) && (w_countNext <= WIDTH'(WARN_LEVEL))
                      && (w_countNext != '0);
        end
    end

    assign o_warn = r_warn;
`else
    assign o_warn = 1'b0;
`endif

    assign o_count = r_count;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule

// File: tb/tb_countdown_timer_multi.sv
// Directed self-checking bench for countdown_timer_multi (WIDTH=10, TICK_DIV=4).
// Expected values are hand-derived from the tick timing: decrement every 4 edges after Start.
module tb_countdown_timer_multi;

    localparam int WIDTH    = 10;
    localparam int TICK_DIV = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             pause = 1'b0;
    logic             abort = 1'b0;
    logic             autoReload = 1'b0;
    logic [WIDTH-1:0] loadValue = '0;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             warn;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    countdown_timer_multi #(
        .WIDTH    (WIDTH),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_pause      (pause),
        .i_abort      (abort),
        .i_autoReload (autoReload),
        .i_loadValue  (loadValue),
        .o_count      (count),
        .o_busy       (busy),
        .o_done       (done),
        .o_warn       (warn)
    );

    // Single comparison point: counts every check and every failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Warn threshold is 3 with the default WARN_LEVEL.
    function automatic int expWarn(input int c, input int b);
`ifdef COUNTDOWN_WARN_EN
        return (b != 0 && c <= 3 && c != 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic checkAll(input string tag, input int c, input int b, input int d);
        checkOutput({tag, ".count"}, 32'(count), 32'(c));
        checkOutput({tag, ".busy"},  32'(busy),  32'(b));
        checkOutput({tag, ".done"},  32'(done),  32'(d));
        checkOutput({tag, ".warn"},  32'(warn),  32'(expWarn(c, b)));
    endtask

    // Advance past the next rising edge and sample 1 ns later.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held for two cycles
        applyStimulus();
        applyStimulus();
        checkAll("reset", 0, 0, 0);
        rst = 1'b0;
        applyStimulus();
        checkAll("postReset", 0, 0, 0);

        // One-shot, LoadValue=7
        start = 1'b1; loadValue = 10'd7; autoReload = 1'b0;
        applyStimulus();
        checkAll("os.k", 7, 1, 0);
        start = 1'b0;
        for (int j = 1; j <= 29; j++) begin
            applyStimulus();
            checkAll($sformatf("os.k+%0d", j), (j < 28) ? 7 - j / 4 : 0, (j < 28) ? 1 : 0, (j == 28) ? 1 : 0);
        end

        // Auto-reload, LoadValue=3, then Abort
        start = 1'b1; loadValue = 10'd3; autoReload = 1'b1;
        applyStimulus();
        checkAll("ar.k", 3, 1, 0);
        start = 1'b0; autoReload = 1'b0;
        for (int j = 1; j <= 30; j++) begin
            applyStimulus();
            checkAll($sformatf("ar.k+%0d", j), 3 - (j % 12) / 4, 1, (j % 12 == 0) ? 1 : 0);
        end
        abort = 1'b1;
        applyStimulus();
        checkAll("ar.abort", 0, 0, 0);
        abort = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            applyStimulus();
            checkAll($sformatf("ar.postAbort%0d", j), 0, 0, 0);
        end

        // LoadValue=5 with Pause sampled on 6 edges after the second decrement
        start = 1'b1; loadValue = 10'd5;
        applyStimulus();
        checkAll("pz.k", 5, 1, 0);
        start = 1'b0;
        for (int j = 1; j <= 27; j++) begin
            pause = (j >= 9 && j <= 14);
            applyStimulus();
            checkAll($sformatf("pz.k+%0d", j),
                     (j < 4) ? 5 : (j < 8) ? 4 : (j < 18) ? 3 : (j < 22) ? 2 : (j < 26) ? 1 : 0,
                     (j < 26) ? 1 : 0, (j == 26) ? 1 : 0);
        end
        pause = 1'b0;

        // Start with LoadValue=0
        start = 1'b1; loadValue = 10'd0;
        applyStimulus();
        checkAll("zero.k", 0, 0, 1);
        start = 1'b0;
        applyStimulus();
        checkAll("zero.k+1", 0, 0, 0);

        // Restart mid-run with LoadValue=9
        start = 1'b1; loadValue = 10'd5;
        applyStimulus();
        start = 1'b0;
        for (int j = 1; j <= 6; j++) applyStimulus();
        checkAll("rs.before", 4, 1, 0);
        start = 1'b1; loadValue = 10'd9;
        applyStimulus();
        checkAll("rs.k", 9, 1, 0);
        start = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            applyStimulus();
            checkAll($sformatf("rs.k+%0d", j), (j < 4) ? 9 : 8, 1, 0);
        end

        // Start coincident with expiry: no Done
        start = 1'b1; loadValue = 10'd2;
        applyStimulus();
        start = 1'b0;
        for (int j = 1; j <= 7; j++) applyStimulus();
        checkAll("coin.k+7", 1, 1, 0);
        start = 1'b1; loadValue = 10'd4;
        applyStimulus();
        checkAll("coin.k+8", 4, 1, 0);
        start = 1'b0;
        applyStimulus();
        checkAll("coin.k+9", 4, 1, 0);

        // Start while Pause high lands in PAUSED and holds
        pause = 1'b1; start = 1'b1; loadValue = 10'd5;
        applyStimulus();
        checkAll("sp.k", 5, 1, 0);
        start = 1'b0;
        for (int j = 1; j <= 5; j++) applyStimulus();
        checkAll("sp.k+5", 5, 1, 0);
        pause = 1'b0; abort = 1'b1;
        applyStimulus();
        checkAll("sp.abort", 0, 0, 0);
        abort = 1'b0;

        // Warn window with LoadValue=6
        start = 1'b1; loadValue = 10'd6;
        applyStimulus();
        checkAll("wn.k", 6, 1, 0);
        start = 1'b0;
        for (int j = 1; j <= 25; j++) begin
            applyStimulus();
            checkAll($sformatf("wn.k+%0d", j), (j < 24) ? 6 - j / 4 : 0, (j < 24) ? 1 : 0, (j == 24) ? 1 : 0);
        end

        // Asynchronous reset mid-run clears outputs before the next edge
        start = 1'b1; loadValue = 10'd7;
        applyStimulus();
        start = 1'b0;
        for (int j = 1; j <= 13; j++) applyStimulus();
        checkAll("ar2.run", 4, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        checkAll("asyncReset", 0, 0, 0);
        applyStimulus();
        rst = 1'b0;
        applyStimulus();
        checkAll("asyncReset.after", 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer_multi.md
Name: countdown_timer_multi

Overview:
- Parametrised successor to the lab's seconds counter: a loadable down-counter with a clock prescaler.
- Supports one-shot and auto-reload modes, plus pause, abort and restart.
- Produces a single-cycle Done pulse on expiry.
- Sits between the switch/key input logic and the HEX display / alarm logic, and replaces the fixed 10-bit seconds counter.

Parameters:
- WIDTH, 10: width of LoadValue and Count.
- TICK_DIV, 4: Clock cycles per count decrement. Must be >= 1. Synthesis sets 50_000_000 for a 1 s tick.
- WARN_LEVEL, 3: Warn threshold (optional feature only).

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- Start  in  1  load LoadValue and begin counting; also restarts a running count.
- Pause  in  1  level; freezes counting while high.
- Abort  in  1  stop immediately, clear Count, no Done.
- AutoReload  in  1  sampled at Start; 1 = reload on expiry, 0 = one-shot.
- LoadValue  in  WIDTH  initial count in ticks.
- Count  out  WIDTH  current remaining count (registered).
- Busy  out  1  high in RUN or PAUSED.
- Done  out  1  one-cycle pulse on expiry.
- Warn  out  1  optional feature; tied 0 when the feature is compiled out.

Behaviour:
- States: IDLE, RUN, PAUSED. Internal registers:
  - prescaler, width clog2(TICK_DIV), minimum 1
  - reload register, WIDTH bits
  - mode bit
- Reset (async) forces: state IDLE, Count 0, prescaler 0, reload 0, mode 0, Busy 0, Done 0, Warn 0.
- Synchronous priority, highest first: Abort > Start > Pause > tick.
- Abort (any state): Count <= 0, prescaler <= 0, state IDLE, Done 0.
- Start (any state, Abort low): at the sampling edge k:
  - Count <= LoadValue, reload <= LoadValue, mode <= AutoReload, prescaler <= 0, state RUN.
  - If LoadValue == 0: go to IDLE instead, and Done pulses for the one cycle after edge k.
- RUN:
  - Prescaler increments each cycle. At TICK_DIV-1 it wraps to 0 and a tick occurs; Count decrements on that same edge.
  - First decrement is at edge k+TICK_DIV.
  - Expiry is a tick while Count == 1, so the final tick lands at edge k+LoadValue*TICK_DIV.
  - On expiry, one-shot (mode 0): Count <= 0, state IDLE, Done high for exactly the following cycle.
  - On expiry, auto-reload (mode 1): Count <= reload (Count never shows 0), stay in RUN, prescaler restarts at 0, Done pulses.
- Pause high in RUN: go to PAUSED on that edge, holding both prescaler and Count.
  - No tick occurs on the pausing edge.
  - Pause low in PAUSED returns to RUN; counting resumes from the held prescaler value.
  - Total expiry latency grows by exactly the number of paused cycles.
- Pause while IDLE has no effect.
- Start while Pause is high: the load happens and state goes to PAUSED, not RUN.
- Start on the same edge as an expiry: Start wins, and no Done is produced.
- Inputs are synchronous; upstream debouncing and edge detection are the user's responsibility.
- Count underflow is impossible by construction; the decrement never wraps.
- Busy = (state != IDLE), registered alongside state.

Optional Feature:
- Macro: COUNTDOWN_WARN_EN.
- Defined: Warn = Busy && (Count <= WARN_LEVEL) && (Count != 0).
  - Warn is registered, so it updates on the same edge as Count.
  - Abort and Reset clear it.
- Undefined: Warn is constant 0, with no comparator logic.

Test Plan (WIDTH=10, TICK_DIV=4):
1. Reset high for 2 cycles, then low -> Count=0, Busy=0, Done=0. Assert Reset asynchronously mid-RUN -> outputs clear before the next clock edge.
2. One-shot, LoadValue=7, Start pulsed at edge k:
   - Count=7 after k.
   - Count steps 6,5,...,1 at edges k+4, k+8, ..., k+24, then 0 at k+28.
   - Done is high only in cycle k+28..k+29; Busy falls at k+28.
3. AutoReload=1, LoadValue=3 -> Count sequence 3,2,1,3,2,1..., Done pulses every 12 cycles. Then Abort -> Count=0, Busy=0, and no further Done.
4. LoadValue=5, Pause held for 6 cycles starting after the 2nd decrement -> Count holds at 3, Done arrives at k+26 (20+6).
5. Corner cases:
   - Start with LoadValue=0 -> Done one cycle later, Busy stays 0.
   - Start re-issued mid-run with LoadValue=9 -> Count=9, prescaler restarts.
   - Start coincident with expiry -> no Done.
6. COUNTDOWN_WARN_EN defined, LoadValue=6 -> Warn rises when Count becomes 3 and falls when Count becomes 0. Macro undefined -> Warn stays 0 throughout.
